paddsb_seq: RTL and testbench
=============================

Name: paddsb_seq

Overview:
- Multi-cycle PADDSB execution unit for the Execute stage. One shared saturating nibble adder is time-multiplexed across the four half-bytes of a 16-bit word.
- The unit sequences nibble lanes LSB-first under a start/busy/done handshake and honours pipeline stall and flush.
- It is the area-reduced alternative to the fully parallel four-adder PADDSB datapath.

Parameters:
- NIB_PER_CYCLE, default 1: nibbles processed per RUN cycle. Legal values are 1, 2 and 4; any other value is an elaboration error. Number of RUN cycles N = 4/NIB_PER_CYCLE.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  launch operation; sampled only in IDLE/DONE with stall=0
- flush  in  1  abort current operation (pipeline kill)
- stall  in  1  freeze all state this cycle
- A  in  16  operand rs {a,b,c,d} nibbles, captured on accepted start
- B  in  16  operand rt {e,f,g,h} nibbles, captured on accepted start
- Sum  out  16  registered result {sat(a+e),sat(b+f),sat(c+g),sat(d+h)}
- busy  out  1  high in RUN
- done  out  1  high in DONE; Sum valid

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; Sum=0, busy=0, done=0, lane index=0; captured operands=0. Reset overrides flush, stall and start, including mid-RUN.
- States IDLE, RUN, DONE; all outputs registered.
- Priority per edge is rst > flush > stall > normal operation.
- IDLE: start=1 → capture A/B, idx=0, go RUN. Sum is not cleared; it keeps the old value until overwritten.
- RUN, per non-stalled edge: compute NIB_PER_CYCLE lanes starting at idx and write those Sum nibbles, then idx += NIB_PER_CYCLE.
  - On the edge that writes lane 3, go DONE.
  - start is ignored in RUN; operands stay the captured copies, and A/B changes have no effect.
- DONE: done=1 and Sum is final.
  - start=1 → capture and go RUN (back-to-back, no idle bubble).
  - Otherwise go IDLE next edge, so done is a one-cycle pulse unless stalled.
- Latency: start accepted at edge k → RUN at edges k+1..k+N → done=1 during the cycle after edge k+N. Plus one cycle per stalled edge.
- stall=1: state, idx, Sum, done and busy hold. A held done stays high.
- flush=1 (not in reset): next state is IDLE, busy=0, done=0, Sum unchanged. Flush wins over a simultaneous start.
- Nibble arithmetic: 4-bit two's-complement add, r=x+y (mod 16).
  - If x[3]=y[3]=0 and r[3]=1 → 4'h7.
  - If x[3]=y[3]=1 and r[3]=0 → 4'h8.
  - Otherwise r. Mixed-sign inputs never saturate. No carry crosses nibble boundaries.
- No subtraction and no overflow output.

Optional Feature:
- Macro PADDSB_SAT_FLAGS_EN.
- Defined: adds output port sat_flags[3:0], one bit per lane (bit i = lane i saturated).
  - Cleared on accepted start and written with the lane result.
  - Held through DONE/IDLE until the next start; reset to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package paddsb_pkg: state enum {IDLE,RUN,DONE}; constants SAT_POS=4'h7, SAT_NEG=4'h8, NIBBLES=4.
- Sub-module nibble_sat_add: combinational 4-bit saturating add, ports x[3:0], y[3:0], r[3:0], sat. Instantiate NIB_PER_CYCLE copies via generate.
- The controller FSM, lane index and result register stay in paddsb_seq.

Test Plan:
- Mixed lanes, NIB_PER_CYCLE=1: A=16'h8FA3, B=16'hF124, start at edge k → done only in the cycle after edge k+4, Sum=16'h80C7, busy high 4 cycles, sat_flags=4'b1000.
- Saturation both ways: A=16'h5555, B=16'h3333 → Sum=16'h7777, sat_flags=4'hF. Then A=16'h9999, B=16'hAAAA → Sum=16'h8888. A=16'h7000, B=16'h9000 → 16'h0000, no flags.
- Stall 3 cycles mid-RUN, and 2 cycles during DONE → done delayed exactly 3 cycles and held 3 cycles total; Sum identical to unstalled run.
- Handshake: start pulsed in RUN with new operands → ignored, result unchanged. start in the DONE cycle with A=16'h1234, B=16'h1111 → busy next cycle, second Sum=16'h2345.
- Abort: flush in 2nd RUN cycle → IDLE, no done pulse, next start runs cleanly. rst mid-RUN → Sum=0, busy=0, done=0 next cycle. flush+start same cycle in DONE → IDLE.
- Parameter sweep, NIB_PER_CYCLE=2 and 4, first vector → latency 2 and 1 RUN cycles, Sum=16'h80C7.

Source files
------------

// File: rtl/paddsb_pkg.sv
// Shared types and constants for the sequential PADDSB unit.
// Latency: none (declarations only). Backpressure: not applicable.
// Holds the controller state encoding and the nibble saturation limits.
package paddsb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SAT_POS = 4'h7;
    localparam logic [3:0] SAT_NEG = 4'h8;
    localparam int         NIBBLES = 4;

endpackage : paddsb_pkg

// File: rtl/paddsb_seq_if.sv
// Handshake and operand/result bundle for paddsb_seq; PADDSB_SAT_FLAGS_EN adds sat_flags.
// Latency: none (wiring only). Backpressure: stall/flush travel with the launch signals.
// master drives start/flush/stall/A/B, slave (the unit) drives Sum/busy/done.
interface paddsb_seq_if;

    logic        start;
    logic        flush;
    logic        stall;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Sum;
    logic        busy;
    logic        done;
`ifdef PADDSB_SAT_FLAGS_EN
    logic [3:0]  sat_flags;
`endif

    modport master (
        output start, flush, stall, A, B,
        input  Sum, busy, done
`ifdef PADDSB_SAT_FLAGS_EN
        , input sat_flags
`endif
    );

    modport slave (
        input  start, flush, stall, A, B,
        output Sum, busy, done
`ifdef PADDSB_SAT_FLAGS_EN
        , output sat_flags
`endif
    );

endinterface : paddsb_seq_if

// File: rtl/nibble_sat_add.sv
// 4-bit two's-complement add that clamps to 7 / -8 on overflow.
// Latency: combinational. Backpressure: none.
// sat flags a clamped result; mixed-sign operands can never overflow.
module nibble_sat_add
    import paddsb_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [3:0] r,
    output logic       sat
);

    logic [3:0] raw;
    logic       pos_ovf;
    logic       neg_ovf;

    assign raw     = x + y;
    assign pos_ovf = ~x[3] & ~y[3] &  raw[3];
    assign neg_ovf =  x[3] &  y[3] & ~raw[3];
    assign sat     = pos_ovf | neg_ovf;

    always_comb begin
        r = raw;
        if (pos_ovf) begin
            r = SAT_POS;
        end else if (neg_ovf) begin
            r = SAT_NEG;
        end
    end

endmodule : nibble_sat_add

// File: rtl/paddsb_seq.sv
// Multi-cycle PADDSB: NIB_PER_CYCLE shared saturating nibble adders walk the 4 lanes LSB-first.
// Latency: 4/NIB_PER_CYCLE RUN cycles after an accepted start, then a one-cycle done pulse.
// Backpressure: stall freezes all state, flush aborts to IDLE; PADDSB_SAT_FLAGS_EN adds sat_flags.
module paddsb_seq #(
    parameter int NIB_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    paddsb_seq_if.slave bus
);
    import paddsb_pkg::*;

    if (NIB_PER_CYCLE != 1 && NIB_PER_CYCLE != 2 && NIB_PER_CYCLE != 4) begin : g_bad_cfg
        $error("paddsb_seq: NIB_PER_CYCLE must be 1, 2 or 4");
    end

    // idx value at which the current RUN cycle writes lane 3
    localparam logic [1:0] LAST_IDX = 2'(NIBBLES - NIB_PER_CYCLE);
    localparam logic [1:0] IDX_STEP = 2'(NIB_PER_CYCLE);

    state_t      state_q, state_d;
    logic [1:0]  idx_q,   idx_d;
    logic [15:0] a_q,     a_d;
    logic [15:0] b_q,     b_d;
    logic [15:0] sum_q,   sum_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
`ifdef PADDSB_SAT_FLAGS_EN
    logic [3:0]  flags_q, flags_d;
`endif

    logic [NIB_PER_CYCLE-1:0][1:0] lane_idx;
    logic [NIB_PER_CYCLE-1:0][3:0] lane_x;
    logic [NIB_PER_CYCLE-1:0][3:0] lane_y;
    logic [NIB_PER_CYCLE-1:0][3:0] lane_r;
`ifdef PADDSB_SAT_FLAGS_EN
    logic [NIB_PER_CYCLE-1:0]      lane_sat;
`else
    logic [NIB_PER_CYCLE-1:0]      lane_sat_unused;
`endif

    // Operand steering: slot j of the shared datapath serves lane idx+j.
    always_comb begin
        lane_idx = '0;
        lane_x   = '0;
        lane_y   = '0;
        for (int j = 0; j < NIB_PER_CYCLE; j++) begin
            lane_idx[j] = idx_q + 2'(j);
            lane_x[j]   = a_q[{lane_idx[j], 2'b00} +: 4];
            lane_y[j]   = b_q[{lane_idx[j], 2'b00} +: 4];
        end
    end

    for (genvar g = 0; g < NIB_PER_CYCLE; g++) begin : g_lane
        nibble_sat_add u_add (
            .x   (lane_x[g]),
            .y   (lane_y[g]),
            .r   (lane_r[g]),
`ifdef PADDSB_SAT_FLAGS_EN
            .sat (lane_sat[g])
`else
            .sat (lane_sat_unused[g])
`endif
        );
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
`ifdef PADDSB_SAT_FLAGS_EN
        flags_d = flags_q;
`endif

        if (bus.flush) begin
            // Abort keeps Sum (and flags) as-is; only control returns to IDLE.
            state_d = IDLE;
            idx_d   = '0;
        end else if (!bus.stall) begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_d     = bus.A;
                        b_d     = bus.B;
                        idx_d   = '0;
                        state_d = RUN;
`ifdef PADDSB_SAT_FLAGS_EN
                        flags_d = '0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    for (int j = 0; j < NIB_PER_CYCLE; j++) begin
                        sum_d[{lane_idx[j], 2'b00} +: 4] = lane_r[j];
`ifdef PADDSB_SAT_FLAGS_EN
                        flags_d[lane_idx[j]] = lane_sat[j];
`endif
                    end
                    idx_d = idx_q + IDX_STEP;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        // Status flags track the next state so they stay registered and hold under stall.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PADDSB_SAT_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PADDSB_SAT_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end

    assign bus.Sum  = sum_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef PADDSB_SAT_FLAGS_EN
    assign bus.sat_flags = flags_q;
`endif

endmodule : paddsb_seq

// File: tb/tb_paddsb_seq.sv
// Bench for paddsb_seq: three instances (NIB_PER_CYCLE = 1, 2, 4) share one stimulus stream.
// A lane-count model with integer clamping is compared every cycle; directed sequences check fixed values.
module tb_paddsb_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic        stall;
    logic [15:0] a_in;
    logic [15:0] b_in;

    logic [15:0] sum_v  [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic [3:0]  flags_v[3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        paddsb_seq_if bus ();
        assign bus.start = start;
        assign bus.flush = flush;
        assign bus.stall = stall;
        assign bus.A     = a_in;
        assign bus.B     = b_in;
        paddsb_seq #(.NIB_PER_CYCLE(1 << g)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign sum_v[g]  = bus.Sum;
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
`ifdef PADDSB_SAT_FLAGS_EN
        assign flags_v[g] = bus.sat_flags;
`else
        assign flags_v[g] = 4'h0;
`endif
    end

    // Reference model: phase 0 idle, 1 running, 2 done; lanes counts lanes already written.
    int          m_ph   [3];
    int          m_lanes[3];
    logic [15:0] m_a    [3];
    logic [15:0] m_b    [3];
    logic [15:0] m_sum  [3];
    logic [3:0]  m_flags[3];

    function automatic int nib_val(input logic [15:0] w, input int lane);
        int n;
        n = int'((w >> (4 * lane)) & 16'h000F);
        return (n >= 8) ? n - 16 : n;
    endfunction

    task automatic model_step();
        for (int g = 0; g < 3; g++) begin
            int npc;
            npc = 1 << g;
            if (rst) begin
                m_ph[g] = 0; m_lanes[g] = 0; m_a[g] = '0; m_b[g] = '0;
                m_sum[g] = '0; m_flags[g] = '0;
            end else if (flush) begin
                m_ph[g] = 0; m_lanes[g] = 0;
            end else if (!stall) begin
                if (m_ph[g] == 1) begin
                    for (int k = 0; k < npc; k++) begin
                        int l, s, c;
                        l = m_lanes[g] + k;
                        s = nib_val(m_a[g], l) + nib_val(m_b[g], l);
                        c = (s > 7) ? 7 : ((s < -8) ? -8 : s);
                        m_sum[g][4*l +: 4] = 4'(c);
                        m_flags[g][l]      = (c != s);
                    end
                    m_lanes[g] = m_lanes[g] + npc;
                    if (m_lanes[g] == 4) m_ph[g] = 2;
                end else if (start) begin
                    m_a[g] = a_in; m_b[g] = b_in; m_lanes[g] = 0;
                    m_flags[g] = '0; m_ph[g] = 1;
                end else begin
                    m_ph[g] = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("model_npc%0d", 1 << g),
                  {14'h0, sum_v[g], busy_v[g], done_v[g]},
                  {14'h0, m_sum[g], 1'(m_ph[g] == 1), 1'(m_ph[g] == 2)});
`ifdef PADDSB_SAT_FLAGS_EN
            check($sformatf("model_flags_npc%0d", 1 << g), {28'h0, flags_v[g]}, {28'h0, m_flags[g]});
`endif
        end
    endtask

    // One clock: model sees the inputs that the DUT samples, then outputs are checked after settling.
    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        compare_all();
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int vi);
        int          lat  [3];
        int          nbusy[3];
        logic [15:0] got  [3];
        logic [3:0]  gotf [3];
        a_in = v.a; b_in = v.b; start = 1'b1;
        tick();
        start = 1'b0;
        for (int g = 0; g < 3; g++) begin
            lat[g] = -1; nbusy[g] = 0; got[g] = '0; gotf[g] = '0;
        end
        for (int c = 0; c < 8; c++) begin
            for (int g = 0; g < 3; g++) begin
                if (busy_v[g]) nbusy[g]++;
                if (done_v[g] && lat[g] < 0) begin
                    lat[g] = c; got[g] = sum_v[g]; gotf[g] = flags_v[g];
                end
            end
            if (c < 7) tick();
        end
        for (int g = 0; g < 3; g++) begin
            check($sformatf("vec%0d_latency_npc%0d", vi, 1 << g), 32'(lat[g]), 32'(4 >> g));
            check($sformatf("vec%0d_busy_cycles_npc%0d", vi, 1 << g), 32'(nbusy[g]), 32'(4 >> g));
            check($sformatf("vec%0d_sum_npc%0d", vi, 1 << g), {16'h0, got[g]}, {16'h0, v.sum});
`ifdef PADDSB_SAT_FLAGS_EN
            check($sformatf("vec%0d_flags_npc%0d", vi, 1 << g), {28'h0, gotf[g]}, {28'h0, v.flags});
`endif
        end
    endtask

    initial begin
        int first_done, n_done;
        logic [15:0] stall_sum;

        vecs[0] = '{16'h8FA3, 16'hF124, 16'h80C7, 4'b1000};
        vecs[1] = '{16'h5555, 16'h3333, 16'h7777, 4'hF};
        vecs[2] = '{16'h9999, 16'hAAAA, 16'h8888, 4'hF};
        vecs[3] = '{16'h7000, 16'h9000, 16'h0000, 4'h0};
        vecs[4] = '{16'h1234, 16'h1111, 16'h2345, 4'h0};
        vecs[5] = '{16'hFFFF, 16'h0101, 16'hF0F0, 4'h0};
        vecs[6] = '{16'h7777, 16'h1111, 16'h7777, 4'hF};
        vecs[7] = '{16'h8888, 16'h8888, 16'h8888, 4'hF};
        vecs[8] = '{16'h0123, 16'h7654, 16'h7777, 4'h0};
        vecs[9] = '{16'h0000, 16'h0000, 16'h0000, 4'h0};

        rst = 1'b1; start = 1'b1; flush = 1'b0; stall = 1'b0;
        a_in = 16'hFFFF; b_in = 16'hFFFF;
        tick();
        for (int g = 0; g < 3; g++)
            check($sformatf("reset_state_npc%0d", 1 << g),
                  {14'h0, sum_v[g], busy_v[g], done_v[g]}, 32'h0);
        rst = 1'b0; start = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) run_vec(vecs[v], v);

        // Stall three edges mid-RUN, then two edges while done is showing.
        a_in = 16'h8FA3; b_in = 16'hF124; start = 1'b1;
        tick();
        start = 1'b0;
        first_done = -1; n_done = 0; stall_sum = '0;
        for (int c = 0; c < 13; c++) begin
            if (done_v[0]) begin
                n_done++;
                if (first_done < 0) begin first_done = c; stall_sum = sum_v[0]; end
            end
            stall = ((c >= 1 && c <= 3) || c == 7 || c == 8);
            tick();
        end
        stall = 1'b0;
        check("stall_done_delay", 32'(first_done), 32'd7);
        check("stall_done_held", 32'(n_done), 32'd3);
        check("stall_sum", {16'h0, stall_sum}, 32'h80C7);

        // start during RUN is ignored; start during DONE launches back-to-back.
        a_in = 16'h8FA3; b_in = 16'hF124; start = 1'b1;
        tick();
        for (int c = 0; c < 11; c++) begin
            if (c == 4) begin
                check("hs_first_done", {31'h0, done_v[0]}, 32'h1);
                check("hs_first_sum", {16'h0, sum_v[0]}, 32'h80C7);
            end
            if (c == 5) check("hs_busy_after_done", {30'h0, busy_v[0], done_v[0]}, 32'h2);
            if (c == 9) begin
                check("hs_second_done", {31'h0, done_v[0]}, 32'h1);
                check("hs_second_sum", {16'h0, sum_v[0]}, 32'h2345);
            end
            if (c == 1 || c == 4) begin
                start = 1'b1; a_in = 16'h1234; b_in = 16'h1111;
            end else begin
                start = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom);
            end
            tick();
        end

        // Flush in the second RUN cycle: no done pulse, then a clean run.
        a_in = 16'h8FA3; b_in = 16'hF124; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_to_idle", {30'h0, busy_v[0], done_v[0]}, 32'h0);
        n_done = 0;
        for (int c = 0; c < 5; c++) begin
            if (done_v[0]) n_done++;
            tick();
        end
        check("flush_no_done", 32'(n_done), 32'd0);
        run_vec(vecs[1], 10);

        // Reset during RUN.
        a_in = 16'h5555; b_in = 16'h3333; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_run", {14'h0, sum_v[0], busy_v[0], done_v[0]}, 32'h0);

        // flush and start together in DONE: flush wins.
        a_in = 16'h9999; b_in = 16'hAAAA; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("fs_in_done", {31'h0, done_v[0]}, 32'h1);
        flush = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0;
        check("fs_idle", {30'h0, busy_v[0], done_v[0]}, 32'h0);
        tick();
        check("fs_stays_idle", {30'h0, busy_v[0], done_v[0]}, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 5);
            stall = ($urandom_range(0, 99) < 15);
            start = ($urandom_range(0, 99) < 40);
            a_in  = 16'($urandom);
            b_in  = 16'($urandom);
            tick();
        end
        rst = 1'b0; flush = 1'b0; stall = 1'b0; start = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_paddsb_seq
